serial_alu_arbiter: RTL and testbench

SERIAL_ALU_ARBITER -- requirements
Module: serial_alu_arbiter

---
 rtl/serial_alu_arbiter.sv | 84 ++++++++
 tb/tb_serial_alu_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_arbiter.sv
// serial_alu_arbiter: two requesters share one 4-bit serial add/sub datapath under round-robin arbitration.
// A 16-bit result is produced LS nibble first, one nibble per enabled cycle.
module serial_alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enb,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  modo0,
    input  logic [1:0]  modo1,
    input  logic [15:0] A0,
    input  logic [15:0] B0,
    input  logic [15:0] A1,
    input  logic [15:0] B1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic [15:0] Q,
    output logic        RCO,
    output logic        done,
    output logic        done_id
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state, state_nx;
    logic [1:0]  op, cnt, sel_modo;
    logic [15:0] a, b;
    logic        c, ptr, win, acc;
    logic [3:0]  a_n, b_n;
    logic [4:0]  res;
    always_comb begin
        win      = (req0 && req1) ? ~ptr : req1;
        sel_modo = win ? modo1 : modo0;
        acc      = enb && state == IDLE && (req0 || req1);
        gnt0     = acc && !win;
        gnt1     = acc && win;
        a_n      = 4'(a >> {cnt, 2'b00});
        b_n      = 4'(b >> {cnt, 2'b00});
        res      = op == 2'b10 ? {1'b0, a_n} - {1'b0, b_n} - {4'b0, c}
                               : {1'b0, a_n} + {1'b0, b_n} + {4'b0, c};
        state_nx = state;
        if (enb)
            case (state)
                IDLE:    if (acc) state_nx = (sel_modo[0] ^ sel_modo[1]) ? RUN : DONE;
                RUN:     if (cnt == 2'd3) state_nx = DONE;
                default: state_nx = IDLE;
            endcase
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= 2'b00;
            a       <= '0;
            b       <= '0;
            cnt     <= '0;
            c       <= 1'b0;
            ptr     <= 1'b1;
            Q       <= '0;
            RCO     <= 1'b0;
            done_id <= 1'b0;
        end else if (enb) begin
            state <= state_nx;
            if (acc) begin
                op      <= sel_modo;
                a       <= win ? A1 : A0;
                b       <= win ? B1 : B0;
                done_id <= win;
                ptr     <= win;
                cnt     <= '0;
                c       <= 1'b0;
                if (!(sel_modo[0] ^ sel_modo[1])) begin
                    Q   <= '0;
                    RCO <= 1'b0;
                end
            end else if (state == RUN) begin
                Q[{cnt, 2'b00} +: 4] <= res[3:0];
                c   <= res[4];
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) RCO <= res[4];
            end
        end
    end
endmodule

// File: tb/tb_serial_alu_arbiter.sv
// tb_serial_alu_arbiter: vector table plus corner sequences; results checked from a scoreboard queue.
module tb_serial_alu_arbiter;
    logic        clk = 0, rst_n = 0, enb = 1, req0 = 0, req1 = 0;
    logic [1:0]  modo0 = 0, modo1 = 0;
    logic [15:0] A0 = 0, B0 = 0, A1 = 0, B1 = 0;
    logic        gnt0, gnt1, busy, RCO, done, done_id;
    logic [15:0] Q;
    int          n_cmp = 0, n_fail = 0, cyc = 0;

    typedef struct {
        bit          id;
        logic [1:0]  modo;
        logic [15:0] a, b, q;
        logic        rco;
        int          lat;
    } vec_t;
    typedef struct {
        logic [15:0] q;
        logic        rco;
        logic        id;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    vec_t vt[10];

    serial_alu_arbiter dut (
        .clk(clk), .rst_n(rst_n), .enb(enb), .req0(req0), .req1(req1),
        .modo0(modo0), .modo1(modo1), .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .Q(Q), .RCO(RCO),
        .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The last done cycle is the one whose closing edge is enabled.
    always @(negedge clk) begin
        if (done && enb) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got Q=%0h id=%0b expected no done", Q, done_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("Q", Q, e.q);
                chk("RCO", RCO, e.rco);
                chk("done_id", done_id, e.id);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input bit id, input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic r, input int lat);
        int n = 0;
        @(negedge clk);
        if (id) begin req1 = 1; modo1 = m; A1 = a; B1 = b; end
        else begin req0 = 1; modo0 = m; A0 = a; B0 = b; end
        #1;
        while (!(gnt0 || gnt1) && n < 20) begin @(negedge clk); #1; n++; end
        if (!(gnt0 || gnt1)) begin
            chk("grant_timeout", 0, 1);
            req0 = 0; req1 = 0;
            return;
        end
        chk("gnt_id", gnt1, id);
        chk("gnt_excl", gnt0 & gnt1, 0);
        exp_q.push_back('{q, r, id, cyc + lat});
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin @(negedge clk); #2; n++; end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        exp_t e;
        s = m == 2'b01 ? {1'b0, a} + {1'b0, b} : {1'b0, a} - {1'b0, b};
        e.q   = (m == 2'b01 || m == 2'b10) ? s[15:0] : 16'h0;
        e.rco = m == 2'b01 ? s[16] : (m == 2'b10 ? (a < b) : 1'b0);
        e.id  = 0;
        e.cyc = (m == 2'b01 || m == 2'b10) ? 5 : 1;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        vt[0] = '{0, 2'b01, 16'h1234, 16'h0FCD, 16'h2201, 0, 5};
        vt[1] = '{0, 2'b01, 16'hFFFF, 16'h0001, 16'h0000, 1, 5};
        vt[2] = '{1, 2'b10, 16'h0005, 16'h0007, 16'hFFFE, 1, 5};
        vt[3] = '{1, 2'b11, 16'hABCD, 16'h1234, 16'h0000, 0, 1};
        vt[4] = '{0, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 1};
        vt[5] = '{0, 2'b10, 16'h8000, 16'h0001, 16'h7FFF, 0, 5};
        vt[6] = '{1, 2'b01, 16'h8000, 16'h8000, 16'h0000, 1, 5};
        vt[7] = '{1, 2'b10, 16'h1234, 16'h1234, 16'h0000, 0, 5};
        vt[8] = '{0, 2'b10, 16'h0000, 16'h0001, 16'hFFFF, 1, 5};
        vt[9] = '{0, 2'b01, 16'h0F0F, 16'h00F1, 16'h1000, 0, 5};

        #1;
        chk("rst_Q", Q, 0);
        chk("rst_RCO", RCO, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Tie after reset: req0 first, req1 granted in the first IDLE cycle after req0's done.
        @(negedge clk);
        req0 = 1; modo0 = 2'b01; A0 = 16'h0001; B0 = 16'h0002;
        req1 = 1; modo1 = 2'b01; A1 = 16'h0010; B1 = 16'h0020;
        #1;
        chk("tie_gnt", {gnt0, gnt1}, 2'b10);
        k = cyc;
        exp_q.push_back('{16'h0003, 1'b0, 1'b0, k + 5});
        @(posedge clk); #1;
        req0 = 0;
        n = 0;
        while (!gnt1 && n < 20) begin @(negedge clk); #1; n++; end
        chk("rr_gnt_cycle", cyc, k + 6);
        exp_q.push_back('{16'h0030, 1'b0, 1'b1, cyc + 5});
        @(posedge clk); #1;
        req1 = 0;
        wait_done();

        for (int i = 0; i < 10; i++) begin
            issue(vt[i].id, vt[i].modo, vt[i].a, vt[i].b, vt[i].q, vt[i].rco, vt[i].lat);
            wait_done();
        end

        // Disabled IDLE never grants.
        @(negedge clk);
        enb = 0; req0 = 1;
        #1;
        chk("gnt_while_disabled", {gnt0, gnt1}, 0);
        enb = 1; req0 = 0;

        // Two stalled cycles in RUN delay done by two, result unchanged.
        issue(0, 2'b01, 16'h1234, 16'h0FCD, 16'h2201, 0, 7);
        @(posedge clk); #1;
        enb = 0;
        @(posedge clk); @(posedge clk); #1;
        enb = 1;
        wait_done();

        // Reset during nibble 2 abandons the op.
        issue(1, 2'b01, 16'h1234, 16'h0FCD, 16'h2201, 0, 5);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 0;
        #1;
        exp_q.delete();
        chk("abort_Q", Q, 0);
        chk("abort_RCO", RCO, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_done_id", done_id, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        issue(0, 2'b11, 16'h5555, 16'h1111, 16'h0000, 0, 1);
        wait_done();

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  m;
            logic [15:0] a, b;
            exp_t        e;
            bit          id;
            m  = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            id = 1'($urandom_range(0, 1));
            e  = model(m, a, b);
            issue(id, m, a, b, e.q, e.rco, e.cyc);
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
